// File: rtl/cordic_cos_sequencer.sv
// cordic_cos_sequencer: float32 front/back end for the iterative CORDIC cosine core.
// Converts a float32 angle (radians) to Q12.20 and range-reduces it into [0, pi/2].
// Starts the core, then re-normalises the signed Q1.20 result back to float32.
// Optional build macro: COS_IN_ROUND_EN -- round-half-up on the float->Q12.20 right shift
// instead of truncation toward zero.
module cordic_cos_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_err_o,
  output logic        cordic_en_o,
  output logic [21:0] cordic_angle_o,
  input  logic [21:0] cordic_cos_i,
  input  logic        cordic_done_i
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONVERT = 3'd1;
  localparam logic [2:0] ST_REDUCE  = 3'd2;
  localparam logic [2:0] ST_FOLD    = 3'd3;
  localparam logic [2:0] ST_ISSUE   = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;
  localparam logic [2:0] ST_NORM    = 3'd6;
  localparam logic [2:0] ST_OUT     = 3'd7;

  // Angle constants in Q.20
  localparam logic [31:0] HALF_PI       = 32'h0019_21FB;
  localparam logic [31:0] PI            = 32'h0032_43F7;
  localparam logic [31:0] THREE_HALF_PI = 32'h004B_65F2;
  localparam logic [31:0] TWO_PI        = 32'h0064_87ED;
  localparam logic [31:0] QNAN          = 32'h7FC0_0000;

  // |x| as unsigned Q12.20; caller guarantees exponent < 139 and not 0xFF.
  function automatic logic [31:0] to_fixed(input logic [7:0] e, input logic [22:0] m);
    logic [23:0] sig;
    logic [7:0]  diff;
    logic [31:0] r;
    sig  = {1'b1, m};
    diff = 8'd0;
    r    = 32'd0;
    if (e >= 8'd130) begin
      diff = e - 8'd130;
      r    = {8'd0, sig} << diff[3:0];
    end else if (e >= 8'd107) begin
      diff = 8'd130 - e;
      r    = {8'd0, sig >> diff[4:0]};
`ifdef COS_IN_ROUND_EN
      r    = r + {31'd0, sig[diff[4:0] - 5'd1]};
`endif
    end else begin
      r = 32'd0;  // zero, denormal or too small to reach one LSB
    end
    return r;
  endfunction

  // Signed Q1.20 cosine to float32; non-positive results collapse to +0.0.
  function automatic logic [31:0] normalise(input logic [21:0] c, input logic sign);
    logic [4:0]  p;
    logic [43:0] w;
    logic [31:0] r;
    p = 5'd0;
    w = 44'd0;
    r = 32'd0;
    if (c[21] || (c == 22'd0)) begin
      r = 32'd0;
    end else begin
      for (int i = 0; i < 21; i++) begin
        p = c[i] ? 5'(i) : p;
      end
      w = {23'd0, c[20:0]} << (5'd23 - p);
      r = {sign, 8'd107 + {3'd0, p}, w[22:0]};
    end
    return r;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] t_q, t_d;
  logic [3:0]  k_q, k_d;
  logic [20:0] a_q, a_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic [21:0] c_q, c_d;
  logic [31:0] res_q, res_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_err_q, out_err_d;
  logic        en_q, en_d;
  logic [20:0] angle_q, angle_d;
  logic [31:0] two_pi_k_s;
  logic [31:0] fold_s;

  assign two_pi_k_s = TWO_PI << k_q;

  // Next-state and datapath decode for the whole sequencer
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    t_d         = t_q;
    k_d         = k_q;
    a_d         = a_q;
    neg_d       = neg_q;
    err_d       = err_q;
    c_d         = c_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    angle_d     = angle_q;
    en_d        = 1'b0;
    fold_s      = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          x_d     = in_data_i;
          state_d = ST_CONVERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if ((x_q[30:23] == 8'hFF) || (x_q[30:23] >= 8'd139)) begin
          err_d   = 1'b1;
          res_d   = QNAN;
          state_d = ST_OUT;
        end else begin
          err_d   = 1'b0;
          t_d     = to_fixed(x_q[30:23], x_q[22:0]);
          k_d     = 4'd9;
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (t_q >= two_pi_k_s) begin
          t_d = t_q - two_pi_k_s;
        end else begin
          t_d = t_q;
        end
        if (k_q == 4'd0) begin
          state_d = ST_FOLD;
        end else begin
          k_d = k_q - 4'd1;
        end
      end
      ST_FOLD: begin
        if (t_q <= HALF_PI) begin
          fold_s = t_q;
          neg_d  = 1'b0;
        end else if (t_q <= PI) begin
          fold_s = PI - t_q;
          neg_d  = 1'b1;
        end else if (t_q <= THREE_HALF_PI) begin
          fold_s = t_q - PI;
          neg_d  = 1'b1;
        end else if (t_q <= TWO_PI) begin
          fold_s = TWO_PI - t_q;
          neg_d  = 1'b0;
        end else begin
          fold_s = 32'd0;
          neg_d  = 1'b0;
        end
        a_d     = fold_s[20:0];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        angle_d = a_q;
        en_d    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cordic_done_i) begin
          c_d     = cordic_cos_i;
          state_d = ST_NORM;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_NORM: begin
        res_d   = normalise(c_q, neg_q);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        // First OUT cycle publishes the result; later cycles wait for the accept.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = res_q;
          out_err_d   = err_q;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 32'd0;
      t_q         <= 32'd0;
      k_q         <= 4'd0;
      a_q         <= 21'd0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      c_q         <= 22'd0;
      res_q       <= 32'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_err_q   <= 1'b0;
      en_q        <= 1'b0;
      angle_q     <= 21'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      t_q         <= t_d;
      k_q         <= k_d;
      a_q         <= a_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      c_q         <= c_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      en_q        <= en_d;
      angle_q     <= angle_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_err_o      = out_err_q;
  assign cordic_en_o    = en_q;
  assign cordic_angle_o = {1'b0, angle_q};

endmodule

// File: tb/tb_cordic_cos_sequencer.sv
// Testbench for cordic_cos_sequencer: directed angles, scoreboard-checked outputs,
// with a behavioural CORDIC core whose done pulse is timed for a 21-cycle accept-to-out_valid latency.
module tb_cordic_cos_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_err_o;
  logic        cordic_en_o;
  logic [21:0] cordic_angle_o;
  logic [21:0] cordic_cos_i;
  logic        cordic_done_i;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;

  typedef struct packed {
    logic [31:0] din;
    logic [20:0] ang;
    logic        err;
    logic        exact;
  } sb_t;

  sb_t sb_q[$];
  real val_q[$];

  localparam real TOL = 1.0 / 65536.0;

  cordic_cos_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_err_o     (out_err_o),
    .cordic_en_o   (cordic_en_o),
    .cordic_angle_o(cordic_angle_o),
    .cordic_cos_i  (cordic_cos_i),
    .cordic_done_i (cordic_done_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    real d;
    d = act - exp;
    total++;
    if (!(d < TOL && d > -TOL)) begin
      bad++;
      $display("FAIL %s: got %f want %f", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) begin
      v = 0.0;
    end else begin
      v = 1.0 + $itor({9'd0, b[22:0]}) / 8388608.0;
      e = int'({24'd0, b[30:23]}) - 127;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
    end
    if (b[31]) v = -v;
    return v;
  endfunction

  // Behavioural CORDIC core: done pulse five edges after the start pulse is seen
  initial begin
    real ang;
    cordic_done_i = 1'b0;
    cordic_cos_i  = 22'd0;
    forever begin
      @(negedge clk);
      if (cordic_en_o === 1'b1) begin
        ang = $itor({11'd0, cordic_angle_o[20:0]}) / 1048576.0;
        repeat (5) @(posedge clk);
        #1;
        cordic_cos_i  = 22'($rtoi($cos(ang) * 1048576.0 + 0.5));
        cordic_done_i = 1'b1;
        @(posedge clk);
        #1;
        cordic_done_i = 1'b0;
      end
    end
  end

  // Count start pulses to the core
  always @(negedge clk) begin
    if (cordic_en_o === 1'b1) en_cnt++;
  end

  // Scoreboard monitor: compare every accepted output against the queued expectation
  always @(negedge clk) begin
    sb_t e;
    real v;
    if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", out_data_o, 32'hxxxx_xxxx);
      end else begin
        e = sb_q.pop_front();
        v = val_q.pop_front();
        chk("out_err", {31'd0, out_err_o}, {31'd0, e.err});
        if (e.err) begin
          chk("err_data", out_data_o, 32'h7FC0_0000);
        end else begin
          chk("cordic_angle", {10'd0, cordic_angle_o}, {11'd0, e.ang});
          chk_real("out_value", f2r(out_data_o), v);
          if (e.exact) begin
            chk("out_exact", out_data_o, 32'h0000_0000);
          end else begin
            chk("out_sign", {31'd0, out_data_o[31]}, {31'd0, (v < 0.0)});
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, (n < 200)}, 32'd1);
  endtask

  task automatic send(input logic [31:0] din, input logic [20:0] ang, input real val,
                      input logic err, input logic exact);
    sb_t e;
    int  lat;
    int  en0;
    e.din = din; e.ang = ang; e.err = err; e.exact = exact;
    sb_q.push_back(e);
    val_q.push_back(val);
    wait_ready();
    en0 = en_cnt;
    in_valid_i = 1'b1;
    in_data_i  = din;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (out_valid_o !== 1'b1 && lat < 100);
    chk("latency", lat, err ? 32'd2 : 32'd21);
    chk("en_pulses", en_cnt - en0, err ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int n;
    int vcnt;
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int n;
    int vcnt;
    logic [20:0] pi_ang;
`ifdef COS_IN_ROUND_EN
    pi_ang = 21'h000000;
`else
    pi_ang = 21'h000001;
`endif
    reset = 1'b1; in_valid_i = 1'b0; in_data_i = 32'd0; out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_out_err", {31'd0, out_err_o}, 32'd0);
    chk("rst_cordic_en", {31'd0, cordic_en_o}, 32'd0);
    chk("rst_cordic_angle", {10'd0, cordic_angle_o}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready_low", {31'd0, in_ready_o}, 32'd0);
    @(negedge clk);
    chk("post_rst_in_ready_high", {31'd0, in_ready_o}, 32'd1);

    send(32'h0000_0000, 21'h000000,  1.0,       1'b0, 1'b0);
    send(32'hBF80_0000, 21'h100000,  0.5403023, 1'b0, 1'b0);
    send(32'h4049_0FDB, pi_ang,     -1.0,       1'b0, 1'b0);
    send(32'h42C8_0000, 21'h087ED0,  0.8623217, 1'b0, 1'b0);
    send(32'h3FC9_0FDB, 21'h1921FB,  0.0,       1'b0, 1'b1);
    send(32'h4080_0000, 21'h0DBC09, -0.6536436, 1'b0, 1'b0);
    send(32'h7FC0_0000, 21'h000000,  0.0,       1'b1, 1'b0);
    send(32'h4580_0000, 21'h000000,  0.0,       1'b1, 1'b0);

    // Backpressure: result must hold while the consumer stalls
    wait_ready();
    out_ready_i = 1'b0;
    send(32'h4000_0000, 21'h1243F7, -0.4161468, 1'b0, 1'b0);
    held = out_data_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", out_data_o, held);
      chk("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
    end
    @(posedge clk); #1; out_ready_i = 1'b1;

    // Reset while waiting on the core: transaction is dropped, late done ignored
    wait_ready();
    in_valid_i = 1'b1; in_data_i = 32'h3F80_0000;
    @(posedge clk); #1; in_valid_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (cordic_en_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_en", {31'd0, (n < 50)}, 32'd1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("midrst_cordic_en", {31'd0, cordic_en_o}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_in_ready_after", {31'd0, in_ready_o}, 32'd1);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1) vcnt++;
    end
    chk("midrst_no_output", vcnt, 32'd0);
    chk("midrst_idle_ready", {31'd0, in_ready_o}, 32'd1);

    send(32'h3F80_0000, 21'h100000, 0.5403023, 1'b0, 1'b0);
    wait_ready();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
